// File: rtl/wav_sector_buffer.sv
// Multi-bank sector buffer: fetches consecutive SD sectors, skips the WAV header, unpacks PCM frames.
// Latency: sample_valid FRAME_BYTES+1 cycles after an accepted sample_req; 1 cycle after a starved one.
// Backpressure: fetch stalls while all banks are full; requests arriving mid-frame are dropped.
//
// Ports: clk_50m/rst (sync, active-high) | enable gates sector fetching |
//        rd_req/rd_sec/rd_data/rd_valid talk to the SD sector reader |
//        sample_req/sample_valid/sample_l/sample_r talk to the codec driver |
//        fill_level = full banks, underrun = sticky starvation flag.
module wav_sector_buffer #(
    parameter int SECTOR_BYTES = 512,
    parameter int NBANKS       = 2,
    parameter int SAMPLE_BITS  = 16,
    parameter int CHANNELS     = 2,
    parameter int OUT_BITS     = 16,
    parameter int START_SECTOR = 0,
    parameter int NUM_SECTORS  = 1024,
    parameter int HEADER_BYTES = 44
) (
    input  logic                        clk_50m,
    input  logic                        rst,
    input  logic                        enable,
    output logic                        rd_req,
    output logic [31:0]                 rd_sec,
    input  logic [7:0]                  rd_data,
    input  logic                        rd_valid,
    input  logic                        sample_req,
    output logic                        sample_valid,
    output logic [OUT_BITS-1:0]         sample_l,
    output logic [OUT_BITS-1:0]         sample_r,
    output logic [$clog2(NBANKS+1)-1:0] fill_level,
    output logic                        underrun
);
    localparam int FRAME_BYTES = SAMPLE_BITS / 8 * CHANNELS;
    localparam int BW = $clog2(NBANKS);
    localparam int CW = $clog2(SECTOR_BYTES + 1);
    localparam int AW = $clog2(NBANKS * SECTOR_BYTES);
    localparam int FW = $clog2(NBANKS + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(SECTOR_BYTES - 1);
    localparam logic [CW-1:0] SEC_END   = CW'(SECTOR_BYTES);
    localparam logic [CW-1:0] HDR       = CW'(HEADER_BYTES);
    localparam logic [31:0]   SEC_FIRST = 32'(START_SECTOR);
    localparam logic [31:0]   SEC_LAST  = 32'(START_SECTOR + NUM_SECTORS - 1);

    if (!((SAMPLE_BITS == 8 || SAMPLE_BITS == 16) && (CHANNELS == 1 || CHANNELS == 2))) begin : g_bad_cfg
        $error("wav_sector_buffer: unsupported SAMPLE_BITS/CHANNELS combination");
    end

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_FILL, F_DONE} fstate_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_WAIT} rstate_t;

    fstate_t f_state, f_next;
    rstate_t r_state, r_next;

    logic [7:0]        mem [0:NBANKS*SECTOR_BYTES-1];
    logic [7:0]        ram_q;
    logic [BW-1:0]     wbank, rbank;
    logic [CW-1:0]     wcnt, rbyte, rstart, rsel;
    logic [31:0]       cur_sec;
    logic [NBANKS-1:0] hdr_flag;     // bank currently holds START_SECTOR
    logic [2:0]        rcnt;         // bytes of the current frame already addressed
    logic [7:0]        fbuf [0:3];
    logic [7:0]        fb   [0:3];
    logic [AW-1:0]     waddr, raddr;
    logic              wr_en, accept, starve, issue, frame_done, bank_end;
    logic [OUT_BITS-1:0] conv_l, conv_r;

    // ---------------- fetch side ----------------
    always_comb begin
        f_next = f_state;
        wr_en  = 1'b0;
        case (f_state)
            F_IDLE: if (enable && fill_level < FW'(NBANKS)) f_next = F_REQ;
            F_REQ: if (rd_valid) begin
                wr_en  = 1'b1;
                f_next = F_FILL;
            end
            F_FILL: if (rd_valid) begin
                wr_en = 1'b1;
                if (wcnt == LAST_BYTE) f_next = F_DONE;
            end
            F_DONE: f_next = F_IDLE;
            default: f_next = F_IDLE;
        endcase
    end

    assign rd_req = (f_state == F_REQ);
    assign rd_sec = rd_req ? cur_sec : '0;
    assign waddr  = AW'(int'(wbank) * SECTOR_BYTES + int'(wcnt));

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            f_state  <= F_IDLE;
            wbank    <= '0;
            wcnt     <= '0;      // drops any partially written bank
            cur_sec  <= SEC_FIRST;
            hdr_flag <= '0;
        end else begin
            f_state <= f_next;
            if (wr_en) wcnt <= wcnt + 1'b1;
            if (f_state == F_DONE) begin
                wcnt            <= '0;
                wbank           <= (wbank == BW'(NBANKS - 1)) ? '0 : wbank + 1'b1;
                hdr_flag[wbank] <= (cur_sec == SEC_FIRST);
                cur_sec         <= (cur_sec == SEC_LAST) ? SEC_FIRST : cur_sec + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (wr_en) mem[waddr] <= rd_data;
        ram_q <= mem[raddr];
    end

    // ---------------- read side ----------------
    // The first byte of a frame is addressed in the accepting cycle itself, so the
    // whole frame is read back-to-back and lands FRAME_BYTES+1 cycles after the request.
    assign rstart = (rbyte == '0 && hdr_flag[rbank]) ? HDR : rbyte;
    assign rsel   = (r_state == R_IDLE) ? rstart : rbyte;
    assign raddr  = AW'(int'(rbank) * SECTOR_BYTES + int'(rsel));

    always_comb begin
        r_next     = r_state;
        accept     = 1'b0;
        starve     = 1'b0;
        issue      = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            R_IDLE: if (sample_req) begin
                if (fill_level != '0) begin
                    accept = 1'b1;
                    r_next = (FRAME_BYTES == 1) ? R_WAIT : R_LOAD;
                end else begin
                    starve = 1'b1;
                end
            end
            R_LOAD: begin
                issue = 1'b1;
                if (rcnt == 3'(FRAME_BYTES - 1)) r_next = R_WAIT;
            end
            R_WAIT: begin
                frame_done = 1'b1;
                r_next     = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign bank_end = frame_done && (rbyte == SEC_END);

    // Last frame byte comes straight from the RAM output; earlier ones were parked in fbuf.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fb[i] = (i == FRAME_BYTES - 1) ? ram_q : fbuf[i];
        end
    end

    if (SAMPLE_BITS == 8) begin : g_s8
        // Unsigned 8-bit WAV: flipping the MSB re-centres it as two's complement.
        always_comb begin
            conv_l = OUT_BITS'({~fb[0][7], fb[0][6:0]}) << (OUT_BITS - 8);
            conv_r = (CHANNELS == 2) ? (OUT_BITS'({~fb[1][7], fb[1][6:0]}) << (OUT_BITS - 8)) : conv_l;
        end
    end else begin : g_s16
        always_comb begin
            conv_l = OUT_BITS'({fb[1], fb[0]}) << (OUT_BITS - 16);
            conv_r = (CHANNELS == 2) ? (OUT_BITS'({fb[3], fb[2]}) << (OUT_BITS - 16)) : conv_l;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (issue) fbuf[2'(rcnt - 3'd1)] <= ram_q;
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state      <= R_IDLE;
            rbank        <= '0;
            rbyte        <= '0;
            rcnt         <= '0;
            sample_valid <= 1'b0;
            sample_l     <= '0;
            sample_r     <= '0;
            underrun     <= 1'b0;
        end else begin
            r_state      <= r_next;
            sample_valid <= 1'b0;
            if (starve) begin
                underrun     <= 1'b1;
                sample_l     <= '0;
                sample_r     <= '0;
                sample_valid <= 1'b1;
            end
            if (accept) begin
                rcnt  <= 3'd1;
                rbyte <= rstart + 1'b1;
            end
            if (issue) begin
                rcnt  <= rcnt + 3'd1;
                rbyte <= rbyte + 1'b1;
            end
            if (frame_done) begin
                sample_l     <= conv_l;
                sample_r     <= conv_r;
                sample_valid <= 1'b1;
                if (bank_end) begin
                    rbank <= (rbank == BW'(NBANKS - 1)) ? '0 : rbank + 1'b1;
                    rbyte <= '0;
                end
            end
        end
    end

    // Bank filled and bank drained in the same cycle cancel out.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            fill_level <= '0;
        end else begin
            case ({f_state == F_DONE, bank_end})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end
endmodule

// File: tb/tb_wav_sector_buffer.sv
module tb_wav_sector_buffer;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst;
    // instance A: 16-bit stereo, 3-sector looping file
    logic        en_a, rd_req_a, rd_valid_a, sreq_a, sval_a, und_a;
    logic [31:0] rd_sec_a;
    logic [7:0]  rd_data_a;
    logic [15:0] sl_a, sr_a;
    logic [1:0]  fill_a;
    // instance B: 8-bit mono
    logic        en_b, rd_req_b, rd_valid_b, sreq_b, sval_b, und_b;
    logic [31:0] rd_sec_b;
    logic [7:0]  rd_data_b;
    logic [15:0] sl_b, sr_b;
    logic [1:0]  fill_b;

    int checks = 0;
    int failures = 0;

    wav_sector_buffer #(.SECTOR_BYTES(64), .NBANKS(2), .SAMPLE_BITS(16), .CHANNELS(2), .OUT_BITS(16),
                        .START_SECTOR(0), .NUM_SECTORS(3), .HEADER_BYTES(44)) u_dut_a (
        .clk_50m(clk), .rst(rst), .enable(en_a), .rd_req(rd_req_a), .rd_sec(rd_sec_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .sample_req(sreq_a), .sample_valid(sval_a),
        .sample_l(sl_a), .sample_r(sr_a), .fill_level(fill_a), .underrun(und_a));

    wav_sector_buffer #(.SECTOR_BYTES(64), .NBANKS(2), .SAMPLE_BITS(8), .CHANNELS(1), .OUT_BITS(16),
                        .START_SECTOR(0), .NUM_SECTORS(3), .HEADER_BYTES(44)) u_dut_b (
        .clk_50m(clk), .rst(rst), .enable(en_b), .rd_req(rd_req_b), .rd_sec(rd_sec_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .sample_req(sreq_b), .sample_valid(sval_b),
        .sample_l(sl_b), .sample_r(sr_b), .fill_level(fill_b), .underrun(und_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // File content for A: header region of sector 0 carries the T1 frame at byte 44.
    function automatic logic [7:0] byte_a(input int sec, input int idx);
        if (sec == 0 && idx == 44) return 8'h34;
        if (sec == 0 && idx == 45) return 8'h12;
        if (sec == 0 && idx == 46) return 8'hCD;
        if (sec == 0 && idx == 47) return 8'hAB;
        return {sec[1:0], idx[5:0]};
    endfunction

    function automatic logic [7:0] byte_b(input int idx);
        if (idx == 44) return 8'h80;
        if (idx == 45) return 8'hFF;
        if (idx == 46) return 8'h00;
        return idx[7:0];
    endfunction

    // {R, L} expected for a 16-bit stereo frame at byte offset off
    function automatic logic [31:0] frame_a(input int sec, input int off);
        return {byte_a(sec, off + 3), byte_a(sec, off + 2), byte_a(sec, off + 1), byte_a(sec, off)};
    endfunction

    task automatic feed_a(input int sec, input int n);
        int w = 0;
        while (!rd_req_a && w < 300) begin tick(); w++; end
        chk("rd_req_a_seen", 32'(rd_req_a), 32'd1);
        chk("rd_sec_a", rd_sec_a, 32'(sec));
        for (int i = 0; i < n; i++) begin
            rd_valid_a = 1'b1;
            rd_data_a  = byte_a(sec, i);
            tick();
        end
        rd_valid_a = 1'b0;
    endtask

    // latency counts the request cycle as cycle 0: sample_valid seen in cycle lat
    task automatic read_a(input string tag, input logic [15:0] el, input logic [15:0] er, input int elat);
        int n = 1;
        sreq_a = 1'b1;
        tick();
        sreq_a = 1'b0;
        while (!sval_a && n < 20) begin tick(); n++; end
        chk({tag, "_lat"}, 32'(n), 32'(elat));
        chk({tag, "_l"}, 32'(sl_a), 32'(el));
        chk({tag, "_r"}, 32'(sr_a), 32'(er));
    endtask

    task automatic read_b(input string tag, input logic [15:0] e, input int elat);
        int n = 1;
        sreq_b = 1'b1;
        tick();
        sreq_b = 1'b0;
        while (!sval_b && n < 20) begin tick(); n++; end
        chk({tag, "_lat"}, 32'(n), 32'(elat));
        chk({tag, "_l"}, 32'(sl_b), 32'(e));
        chk({tag, "_r"}, 32'(sr_b), 32'(e));
    endtask

    initial begin
        logic [31:0] f;
        int w;
        rst = 1'b1;
        en_a = 0; rd_valid_a = 0; rd_data_a = 0; sreq_a = 0;
        en_b = 0; rd_valid_b = 0; rd_data_b = 0; sreq_b = 0;
        repeat (3) tick();
        chk("rst_rd_req", 32'(rd_req_a), 32'd0);
        chk("rst_fill", 32'(fill_a), 32'd0);
        chk("rst_sval", 32'(sval_a), 32'd0);
        chk("rst_underrun", 32'(und_a), 32'd0);
        chk("rst_sl", 32'(sl_a), 32'd0);
        rst = 1'b0;
        tick();

        // T2: 8-bit mono conversion and duplication
        en_b = 1'b1;
        w = 0;
        while (!rd_req_b && w < 50) begin tick(); w++; end
        chk("b_rd_sec", rd_sec_b, 32'd0);
        for (int i = 0; i < 64; i++) begin
            rd_valid_b = 1'b1;
            rd_data_b  = byte_b(i);
            tick();
        end
        rd_valid_b = 1'b0;
        en_b = 1'b0;
        repeat (3) tick();
        chk("b_fill", 32'(fill_b), 32'd1);
        read_b("t2_80", 16'h0000, 2);
        read_b("t2_ff", 16'h7F00, 2);
        read_b("t2_00", 16'h8000, 2);

        // T5: starved request
        read_a("t5", 16'h0000, 16'h0000, 1);
        chk("t5_underrun", 32'(und_a), 32'd1);
        repeat (5) tick();
        chk("t5_underrun_sticky", 32'(und_a), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_underrun_cleared", 32'(und_a), 32'd0);
        rst = 1'b0;
        tick();

        // T3: both banks fill, then fetching stops
        en_a = 1'b1;
        feed_a(0, 64);
        feed_a(1, 64);
        repeat (10) begin
            tick();
            chk("t3_no_req", 32'(rd_req_a), 32'd0);
        end
        chk("t3_fill", 32'(fill_a), 32'd2);

        // T1: first frame after the header
        read_a("t1", 16'h1234, 16'hABCD, 5);
        tick();
        chk("t1_sval_pulse", 32'(sval_a), 32'd0);
        for (int o = 48; o < 64; o += 4) begin
            f = frame_a(0, o);
            read_a("s0", f[15:0], f[31:16], 5);
        end
        chk("t3_fill_drained", 32'(fill_a), 32'd1);
        feed_a(2, 64);
        repeat (3) tick();
        chk("t3_fill_refill", 32'(fill_a), 32'd2);

        read_a("s1_first", 16'h4140, 16'h4342, 5);
        for (int o = 4; o < 64; o += 4) begin
            f = frame_a(1, o);
            read_a("s1", f[15:0], f[31:16], 5);
        end
        // T4: wrap back to the first sector
        feed_a(0, 64);
        for (int o = 0; o < 64; o += 4) begin
            f = frame_a(2, o);
            read_a("s2", f[15:0], f[31:16], 5);
        end
        read_a("t4_loop_hdr", 16'h1234, 16'hABCD, 5);

        // T6: reset mid-sector
        feed_a(1, 40);
        rst = 1'b1;
        tick();
        chk("t6_rd_req", 32'(rd_req_a), 32'd0);
        chk("t6_fill", 32'(fill_a), 32'd0);
        rst = 1'b0;
        feed_a(0, 64);
        repeat (3) tick();
        read_a("t6_hdr", 16'h1234, 16'hABCD, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
